fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 65 ++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and IF/ID fetch stage; the IF/ID pipeline register is built only when PIPE_IF_ID_EN is defined
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        BrTaken,
    input  logic        UncondBr,
    input  logic [25:0] br_addr26,
    input  logic [18:0] cond_addr19,
    input  logic        stall,
    input  logic        flush,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid
);
    logic [63:0] r_pc;
    logic [63:0] w_off;
    logic [63:0] w_target;
    logic        w_taken;
    assign w_off     = UncondBr ? {{38{br_addr26[25]}}, br_addr26} : {{45{cond_addr19[18]}}, cond_addr19};
    assign w_target  = instr_pc + (w_off << 2);
    assign w_taken   = BrTaken & instr_valid;
    assign imem_addr = r_pc;
`ifdef PIPE_IF_ID_EN
    logic [31:0] r_instr;
    logic [63:0] r_instr_pc;
    logic        r_valid;
    // reset > flush > stall > taken branch (squashes wrong-path fetch) > sequential fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            if (w_taken) begin
                r_pc    <= w_target;
                r_valid <= 1'b0;
            end else begin
                r_pc       <= r_pc + 64'd4;
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
                r_valid    <= 1'b1;
            end
        end
    end
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
`else
    logic w_hold;
    assign instr       = imem_rdata;
    assign instr_pc    = r_pc;
    assign instr_valid = ~reset;
    assign w_hold      = stall | (flush & 1'b0);
    // single-cycle: only the PC is state; flush has no effect here
    always_ff @(posedge clk) begin
        if (reset) r_pc <= '0;
        else if (!w_hold) r_pc <= w_taken ? w_target : r_pc + 64'd4;
    end
`endif
endmodule
